// File: rtl/joypad_poller.sv
// Periodic poll scheduler for the NES-classic I2C bridge: issues start pulses at a fixed
// rate, supervises each transaction with a watchdog and publishes clean joypad state.
module joypad_poller #(
   parameter int unsigned POLL_PERIOD = 833_333,
   parameter int unsigned TIMEOUT     = 200_000,
   parameter int unsigned MISS_LIMIT  = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   output logic       bridge_start_o,
   input  logic       bridge_ready_i,
   input  logic [7:0] bridge_joypad_i,
   input  logic       bridge_valid_i,
   output logic [7:0] joypad_o,
   output logic [7:0] pressed_o,
   input  logic       frame_ack_i,
   output logic       new_sample_o,
   output logic       connected_o,
   output logic [7:0] err_count_o
);

   localparam int unsigned CNT_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
   localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(POLL_PERIOD - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);
   localparam logic [3:0]       MISS_LIM    = 4'(MISS_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_BUSY   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [3:0]       miss_q, miss_d;
   logic [7:0]       joypad_q, joypad_d;
   logic [7:0]       pressed_q, pressed_d;
   logic             new_sample_q, new_sample_d;
   logic             connected_q, connected_d;
   logic [7:0]       err_q, err_d;

   logic             tick;
   logic             done_ok;
   logic             done_fail;
   logic [3:0]       miss_inc;

   // Free-running poll timebase, independent of enable and of the FSM.
   always_comb begin
      tick  = (cnt_q == PERIOD_LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      to_d           = to_q;
      bridge_start_o = 1'b0;
      done_ok        = 1'b0;
      done_fail      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // Ticks that miss any start condition are simply dropped.
            if (tick && enable_i && bridge_ready_i) begin
               bridge_start_o = 1'b1;
               state_d        = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // The bridge still shows ready in this cycle; skip it.
            state_d = S_BUSY;
            to_d    = '0;
         end
         S_BUSY: begin
            to_d = to_q + 1'b1;
            if (bridge_ready_i) begin
               done_ok   = bridge_valid_i;
               done_fail = ~bridge_valid_i;
               state_d   = S_IDLE;
            end else if (to_q == TO_LAST) begin
               done_fail = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      joypad_d     = joypad_q;
      pressed_d    = pressed_q;
      new_sample_d = 1'b0;
      connected_d  = connected_q;
      err_d        = err_q;
      miss_d       = miss_q;
      miss_inc     = (miss_q >= MISS_LIM) ? MISS_LIM : miss_q + 1'b1;
      if (done_ok) begin
         // Ack drops the old flags while edges from this sample still register.
         joypad_d     = bridge_joypad_i;
         pressed_d    = (pressed_q & ~{8{frame_ack_i}}) | (bridge_joypad_i & ~joypad_q);
         new_sample_d = 1'b1;
         connected_d  = 1'b1;
         miss_d       = '0;
      end else begin
         if (frame_ack_i) begin
            pressed_d = '0;
         end
         if (done_fail) begin
            if (err_q != 8'hFF) begin
               err_d = err_q + 1'b1;
            end
            miss_d = miss_inc;
            if (miss_inc == MISS_LIM) begin
               connected_d = 1'b0;
               joypad_d    = '0;
               pressed_d   = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         joypad_q     <= '0;
         pressed_q    <= '0;
         new_sample_q <= 1'b0;
         connected_q  <= 1'b0;
         err_q        <= '0;
         miss_q       <= '0;
      end else begin
         joypad_q     <= joypad_d;
         pressed_q    <= pressed_d;
         new_sample_q <= new_sample_d;
         connected_q  <= connected_d;
         err_q        <= err_d;
         miss_q       <= miss_d;
      end
   end

   assign joypad_o     = joypad_q;
   assign pressed_o    = pressed_q;
   assign new_sample_o = new_sample_q;
   assign connected_o  = connected_q;
   assign err_count_o  = err_q;

endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench for joypad_poller with a bridge model of programmable latency/valid.
module tb_joypad_poller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable;
   logic       bridge_start;
   logic       br_ready;
   logic [7:0] br_joy;
   logic       br_valid;
   logic [7:0] joypad;
   logic [7:0] pressed;
   logic       frame_ack;
   logic       new_sample;
   logic       connected;
   logic [7:0] err_count;

   int   vecs = 0;
   int   errs = 0;
   int unsigned cyc;
   int   n_start = 0;
   int   n_ns = 0;
   int   rem;
   int   cfg_lat;
   logic cfg_valid;
   logic [7:0] cfg_joy;
   logic hang;
   int   s0;

   joypad_poller #(.POLL_PERIOD(100), .TIMEOUT(50), .MISS_LIMIT(2)) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable),
      .bridge_start_o(bridge_start), .bridge_ready_i(br_ready),
      .bridge_joypad_i(br_joy), .bridge_valid_i(br_valid),
      .joypad_o(joypad), .pressed_o(pressed), .frame_ack_i(frame_ack),
      .new_sample_o(new_sample), .connected_o(connected), .err_count_o(err_count)
   );

   always #5 clk = ~clk;

   // cyc equals the DUT period count until the first wrap after reset release.
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   // Bridge model: ready drops the edge after start, rises rem+1 cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         br_ready <= 1'b1; br_valid <= 1'b0; br_joy <= 8'h00; rem <= 0;
      end else if (bridge_start) begin
         br_ready <= 1'b0; rem <= cfg_lat;
      end else if (!br_ready && !hang) begin
         if (rem == 0) begin
            br_ready <= 1'b1; br_valid <= cfg_valid; br_joy <= cfg_joy;
         end else begin
            rem <= rem - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (bridge_start) n_start <= n_start + 1;
      if (new_sample)   n_ns    <= n_ns + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int unsigned target);
      int g = 0;
      @(negedge clk);
      while (cyc < target && g < 40000) begin
         @(negedge clk);
         g++;
      end
      chk("wait_cyc", cyc, target);
   endtask

   initial begin
      enable = 1'b1; frame_ack = 1'b0;
      cfg_lat = 20; cfg_valid = 1'b1; cfg_joy = 8'h05; hang = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_start", bridge_start, 0);
      chk("rst_joypad", joypad, 0);
      chk("rst_pressed", pressed, 0);
      chk("rst_new_sample", new_sample, 0);
      chk("rst_connected", connected, 0);
      chk("rst_err", err_count, 0);
      rst = 1'b0;

      // nominal poll
      wait_cyc(98);
      chk("nom_no_early_start", bridge_start, 0);
      chk("nom_start_cnt0", n_start, 0);
      wait_cyc(99);
      chk("nom_start_99", bridge_start, 1);
      wait_cyc(121);
      chk("nom_pre_joypad", joypad, 0);
      chk("nom_pre_ns", new_sample, 0);
      wait_cyc(122);
      chk("nom_joypad", joypad, 8'h05);
      chk("nom_pressed", pressed, 8'h05);
      chk("nom_ns", new_sample, 1);
      chk("nom_connected", connected, 1);
      wait_cyc(123);
      chk("nom_ns_one_cycle", new_sample, 0);
      chk("nom_ns_count", n_ns, 1);

      // edge + ack in the success cycle
      cfg_joy = 8'h06;
      wait_cyc(199);
      chk("ack_start_199", bridge_start, 1);
      wait_cyc(221);
      frame_ack = 1'b1;
      wait_cyc(222);
      frame_ack = 1'b0;
      chk("ack_joypad", joypad, 8'h06);
      chk("ack_pressed", pressed, 8'h02);
      chk("ack_ns", new_sample, 1);
      wait_cyc(230);
      frame_ack = 1'b1;
      wait_cyc(231);
      frame_ack = 1'b0;
      chk("ack_alone_clears", pressed, 8'h00);

      // timeout, twice
      wait_cyc(250);
      hang = 1'b1;
      wait_cyc(350);
      chk("to_err_before", err_count, 0);
      wait_cyc(351);
      chk("to_err_1", err_count, 1);
      chk("to_joypad_hold", joypad, 8'h06);
      chk("to_conn_hold", connected, 1);
      wait_cyc(400);
      chk("to_no_start_busy", n_start, 3);
      wait_cyc(410);
      hang = 1'b0;
      wait_cyc(450);
      hang = 1'b1;
      wait_cyc(551);
      chk("to_err_2", err_count, 2);
      chk("to_disconnect", connected, 0);
      chk("to_joypad_zero", joypad, 0);

      // reconnect flags every held button
      cfg_joy = 8'h03;
      wait_cyc(560);
      hang = 1'b0;
      wait_cyc(622);
      chk("rc_joypad", joypad, 8'h03);
      chk("rc_pressed", pressed, 8'h03);
      chk("rc_connected", connected, 1);

      // invalid completion
      wait_cyc(650);
      cfg_valid = 1'b0; cfg_lat = 5;
      wait_cyc(707);
      chk("inv_err", err_count, 3);
      chk("inv_joypad_hold", joypad, 8'h03);
      chk("inv_miss", dut.miss_q, 1);
      chk("inv_connected", connected, 1);
      wait_cyc(807);
      chk("inv2_err", err_count, 4);
      chk("inv2_disconnect", connected, 0);
      chk("inv2_pressed_zero", pressed, 0);

      // enable low for 5 periods
      wait_cyc(810);
      enable = 1'b0; cfg_lat = 0;
      wait_cyc(1310);
      chk("dis_no_starts", n_start, 7);
      enable = 1'b1;

      // 300 invalid polls saturate the error counter
      wait_cyc(26302);
      chk("sat_254", err_count, 8'd254);
      wait_cyc(26402);
      chk("sat_255", err_count, 8'd255);
      wait_cyc(31310);
      chk("sat_hold", err_count, 8'd255);
      cfg_valid = 1'b1; cfg_joy = 8'h81;
      wait_cyc(31402);
      chk("pre_rst_joypad", joypad, 8'h81);
      chk("pre_rst_pressed", pressed, 8'h81);
      chk("pre_rst_connected", connected, 1);
      cfg_lat = 30;

      // async reset while busy
      wait_cyc(31510);
      rst = 1'b1;
      #1;
      chk("arst_joypad", joypad, 0);
      chk("arst_pressed", pressed, 0);
      chk("arst_connected", connected, 0);
      chk("arst_err", err_count, 0);
      chk("arst_ns", new_sample, 0);
      chk("arst_start", bridge_start, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      s0 = n_start;
      wait_cyc(98);
      chk("arst_no_early_start", n_start, s0);
      wait_cyc(99);
      chk("arst_start_99", bridge_start, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/joypad_poller.md
# joypad_poller

Periodic poll scheduler for the NES-classic I2C bridge. It issues bridge start pulses at a fixed rate and supervises each transaction with a watchdog. It latches completed samples into a stable joypad register, derives sticky "pressed" edge flags for game logic, and tracks controller presence. It sits between `nes_bridge` and the game core, which sees only clean per-frame button state.

## Interface
- `POLL_PERIOD`, default 833_333: clocks between poll ticks (60 Hz at 50 MHz); must be ≥ 4.
- `TIMEOUT`, default 200_000: max clocks a transaction may stay busy before it is declared failed.
- `MISS_LIMIT`, default 3: consecutive failed polls before `connected` drops; range 1–15.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, ticks are ignored; an in-flight transaction still completes.
- `bridge_start`  out  1  one-cycle start pulse to `nes_bridge.start`.
- `bridge_ready`  in  1  `nes_bridge.ready`.
- `bridge_joypad`  in  8  `nes_bridge.joypad`.
- `bridge_valid`  in  1  `nes_bridge.joypad_valid`.
- `joypad`  out  8  last good sample; forced 0 while disconnected.
- `pressed`  out  8  sticky rising-edge flags per button.
- `frame_ack`  in  1  single-cycle pulse; clears all `pressed` bits.
- `new_sample`  out  1  one-cycle pulse when `joypad` updates.
- `connected`  out  1  controller present.
- `err_count`  out  8  failed polls, saturating at 255.

## Operation
- Reset values: `bridge_start`=0, `joypad`=0, `pressed`=0, `new_sample`=0, `connected`=0, `err_count`=0, state=S_IDLE, period counter=0, miss counter=0, timeout counter=0.
- Period counter:
  - Free-running 0..POLL_PERIOD-1, wraps to 0.
  - `tick` is asserted when the count equals POLL_PERIOD-1.
- S_IDLE:
  - On `tick` && `enable` && `bridge_ready`: drive `bridge_start`=1 for that cycle, go to S_LAUNCH.
  - A tick that fails any of these conditions is dropped; there is no catch-up.
- S_LAUNCH: wait exactly one cycle, because the bridge deasserts `ready` one cycle after start. Then go to S_BUSY and clear the timeout counter.
- S_BUSY: increment the timeout counter every cycle.
  - If `bridge_ready`=1 && `bridge_valid`=1: success, go to S_IDLE.
  - If `bridge_ready`=1 && `bridge_valid`=0: failure, go to S_IDLE.
  - Else, when the timeout counter reaches TIMEOUT-1: failure, go to S_IDLE. If the bridge is still busy, no new start is issued until `bridge_ready` returns.
- On success:
  - `joypad` ← `bridge_joypad`.
  - `pressed` ← (`pressed` & ~{8{frame_ack}}) | (`bridge_joypad` & ~`joypad`_old).
  - Pulse `new_sample`, set `connected`=1, clear the miss counter.
- On failure:
  - `err_count` += 1, saturating at 255.
  - Miss counter += 1, saturating at MISS_LIMIT.
  - When the miss counter reaches MISS_LIMIT: `connected`=0, `joypad`←0, `pressed`←0.
- `frame_ack` without a success in the same cycle: `pressed`←0.
- Simultaneous success and `frame_ack`: previously pressed bits clear, newly risen bits survive.
- Reconnect after a disconnect: the first success edge-detects against `joypad`=0, so every held button is flagged pressed.
- Asserting `rst` mid-transaction returns all registers to reset values immediately. The bridge is reset by the same system reset.

## Timing
- `bridge_start` is high in the same cycle the period counter equals POLL_PERIOD-1, when all start conditions hold.
- Completion is seen in cycle N (S_BUSY with `bridge_ready`=1). The `joypad`, `pressed`, `new_sample`, `connected`, and `err_count` updates are all visible after edge N+1.
- `new_sample` is high for exactly one cycle per success.
- The timeout fires TIMEOUT cycles after entry to S_BUSY.
- Minimum spacing between `bridge_start` pulses is POLL_PERIOD cycles.

## Test plan
- Bench parameters: POLL_PERIOD=100, TIMEOUT=50, MISS_LIMIT=2, with a bridge model that has programmable latency and programmable valid.
- Nominal poll:
  - Stimulus: bridge returns `bridge_joypad`=0x05 with valid after 20 cycles.
  - Required: `bridge_start` at cycle 99; `joypad`=0x05, `pressed`=0x05, one `new_sample` pulse, `connected`=1.
- Edge and ack:
  - Stimulus: next sample 0x06; `frame_ack` pulsed in the same cycle as success.
  - Required: `pressed`=0x02 (bit 2 was previously set and is cleared; bit 1 newly rose).
- Timeout:
  - Stimulus: bridge never raises `ready` for two polls.
  - Required: `err_count`=1 after 50 busy cycles. No start is issued while `bridge_ready`=0. After the second failure, `connected`=0 and `joypad`=0.
- Invalid completion:
  - Stimulus: bridge raises `ready` with `bridge_valid`=0.
  - Required: `err_count` increments, `joypad` holds, miss counter=1, `connected` stays 1.
- Enable and saturation:
  - Stimulus: hold `enable`=0 for 5 periods, then force 300 failures.
  - Required: zero `bridge_start` pulses while disabled; `err_count` stays at 255.
- Async reset:
  - Stimulus: assert `rst` during S_BUSY.
  - Required: all outputs return to reset values without waiting for a clock edge; the first start after release comes at cycle 99.
